serial_word_queue: RTL and testbench

//  Parametrised serial-in / serial-out word queue: deserialises bits from data_in into WORD_W-bit

---
 rtl/serial_word_queue.sv | 171 +++++++++++++++++
 tb/tb_serial_word_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_queue.sv
// Serial-in/serial-out word queue: bit deserialiser -> DEPTH-entry circular FIFO -> MSB-first serialiser.
// Optional even parity on both serial sides is enabled by defining the macro PARITY_EN.
`timescale 1ns/1ps
module serial_word_queue #(
   parameter int  WORD_W = 8,
   parameter int  DEPTH  = 8,
   localparam int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic             clock_1MHz,
   input  logic             rst,
   input  logic             data_in,
   input  logic             write_in,
   input  logic             enqueue_in,
   input  logic             dequeue_in,
   output logic             status_out,
   output logic             data_out,
   output logic             data_valid_out,
   output logic [CNT_W-1:0] len_out,
   output logic             full_out,
   output logic             empty_out,
   output logic             overflow_out,
   output logic             parity_err_out
);

`ifdef PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int FRAME_W = WORD_W + PAR_W;
   localparam int BC_W    = $clog2(FRAME_W+1);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(FRAME_W-1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
   localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(DEPTH);

   typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SHIFT}   tx_state_t;

   rx_state_t          rx_state_q, rx_state_d;
   tx_state_t          tx_state_q, tx_state_d;
   logic [FRAME_W-1:0] rx_sr_q, rx_sr_d;
   logic [BC_W-1:0]    rx_cnt_q, rx_cnt_d;
   logic [FRAME_W-1:0] tx_sr_q, tx_sr_d;
   logic [BC_W-1:0]    tx_cnt_q, tx_cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic               full_q, empty_q, ovf_q, ovf_d, perr_q, perr_d;
   logic [WORD_W-1:0]  mem [DEPTH];
   logic               push, pop;
   logic [FRAME_W-1:0] rx_frame;
   logic [WORD_W-1:0]  rx_word, head_word;

   always_comb begin
      rx_frame   = {rx_sr_q[FRAME_W-2:0], data_in};
      rx_word    = rx_sr_q[FRAME_W-1 -: WORD_W];
      head_word  = mem[rd_ptr_q];
      // A pop frees a slot on the same edge, so a full queue still accepts a push alongside it.
      pop        = dequeue_in && !empty_q && (tx_state_q == TX_IDLE);
      push       = enqueue_in && (rx_state_q == RX_HOLD) && (!full_q || pop);

      rx_state_d = rx_state_q;
      rx_sr_d    = rx_sr_q;
      rx_cnt_d   = rx_cnt_q;
      ovf_d      = ovf_q;
      perr_d     = 1'b0;
      case (rx_state_q)
         RX_COLLECT: begin
            if (write_in) begin
               rx_sr_d = rx_frame;
               if (rx_cnt_q == LAST_BIT) begin
                  rx_cnt_d = '0;
`ifdef PARITY_EN
                  if (^rx_frame) perr_d = 1'b1;
                  else           rx_state_d = RX_HOLD;
`else
                  rx_state_d = RX_HOLD;
`endif
               end else begin
                  rx_cnt_d = rx_cnt_q + 1'b1;
               end
            end
         end
         RX_HOLD: begin
            if (push)            rx_state_d = RX_COLLECT;
            else if (enqueue_in) ovf_d      = 1'b1;
         end
         default: rx_state_d = RX_COLLECT;
      endcase

      tx_state_d = tx_state_q;
      tx_sr_d    = tx_sr_q;
      tx_cnt_d   = tx_cnt_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (pop) begin
`ifdef PARITY_EN
               tx_sr_d = {head_word, ^head_word};
`else
               tx_sr_d = head_word;
`endif
               tx_cnt_d   = '0;
               tx_state_d = TX_SHIFT;
            end
         end
         TX_SHIFT: begin
            // Zero-fill so the shifter is empty (data_out low) once the last bit is out.
            tx_sr_d = {tx_sr_q[FRAME_W-2:0], 1'b0};
            if (tx_cnt_q == LAST_BIT) tx_state_d = TX_IDLE;
            else                      tx_cnt_d   = tx_cnt_q + 1'b1;
         end
         default: tx_state_d = TX_IDLE;
      endcase

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   len_d = len_q + 1'b1;
         2'b01:   len_d = len_q - 1'b1;
         default: len_d = len_q;
      endcase
   end

   always_ff @(posedge clock_1MHz or posedge rst) begin
      if (rst) begin
         rx_state_q <= RX_COLLECT;
         tx_state_q <= TX_IDLE;
         rx_sr_q    <= '0;
         rx_cnt_q   <= '0;
         tx_sr_q    <= '0;
         tx_cnt_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         len_q      <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         ovf_q      <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         tx_state_q <= tx_state_d;
         rx_sr_q    <= rx_sr_d;
         rx_cnt_q   <= rx_cnt_d;
         tx_sr_q    <= tx_sr_d;
         tx_cnt_q   <= tx_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         len_q      <= len_d;
         full_q     <= (len_d == LEN_FULL);
         empty_q    <= (len_d == '0);
         ovf_q      <= ovf_d;
         perr_q     <= perr_d;
      end
   end

   always_ff @(posedge clock_1MHz) begin
      if (push) mem[wr_ptr_q] <= rx_word;
   end

   assign status_out     = (rx_state_q == RX_COLLECT);
   assign data_valid_out = (tx_state_q == TX_SHIFT);
   assign data_out       = tx_sr_q[FRAME_W-1] & data_valid_out;
   assign len_out        = len_q;
   assign full_out       = full_q;
   assign empty_out      = empty_q;
   assign overflow_out   = ovf_q;
   assign parity_err_out = perr_q;

endmodule

// File: tb/tb_serial_word_queue.sv
// Directed bench for serial_word_queue (WORD_W=8, DEPTH=4): table-driven single-word pass plus
// hand-written full/overflow/wrap/reset sequences; parity sequences when PARITY_EN is defined.
`timescale 1ns/1ps
module tb_serial_word_queue;
   localparam int WORD_W = 8;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic clk = 1'b0;
   logic rst, din, wr, enq, deq;
   logic status_out, data_out, data_valid_out, full_out, empty_out, overflow_out, parity_err_out;
   logic [CNT_W-1:0] len_out;

   int n_cmp = 0;
   int n_bad = 0;

   // {status, valid, data, len[2:0], full, empty, overflow, parity_err}
   logic [9:0] obs;
   assign obs = {status_out, data_valid_out, data_out, len_out, full_out, empty_out,
                 overflow_out, parity_err_out};
   localparam logic [9:0] RST_OBS = 10'b1_0_0_000_0_1_0_0;

   typedef struct packed {
      logic       din, wr, enq, deq;
      logic [9:0] exp;
   } vec_t;
   vec_t tbl [18];

   serial_word_queue #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
      .clock_1MHz    (clk),
      .rst           (rst),
      .data_in       (din),
      .write_in      (wr),
      .enqueue_in    (enq),
      .dequeue_in    (deq),
      .status_out    (status_out),
      .data_out      (data_out),
      .data_valid_out(data_valid_out),
      .len_out       (len_out),
      .full_out      (full_out),
      .empty_out     (empty_out),
      .overflow_out  (overflow_out),
      .parity_err_out(parity_err_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic d, w, e, q, st, v, dq, input logic [2:0] len,
                               input logic f, em, o);
      mk = {d, w, e, q, st, v, dq, len, f, em, o, 1'b0};
   endfunction

   // Inputs are applied on the falling edge and outputs are observed at the next falling edge.
   task automatic step(input logic d, w, e, q);
      din = d; wr = w; enq = e; deq = q;
      @(negedge clk);
   endtask

   task automatic send_bits(input logic [15:0] f, input int n);
      for (int i = n - 1; i >= 0; i--) step(f[i], '1, '0, '0);
   endtask

   task automatic recv(input logic do_pop, input int n, output logic [15:0] w);
      int bad;
      bad = 0;
      w   = '0;
      if (do_pop) step('0, '0, '0, '1);
      for (int i = 0; i < n; i++) begin
         if (data_valid_out !== 1'b1) bad++;
         w = {w[14:0], data_out};
         step('0, '0, '0, '0);
      end
      check("tx_valid_window", 16'(bad), 16'd0);
      check("tx_valid_end", 16'({data_valid_out, data_out}), 16'd0);
   endtask

   task automatic pulse_reset();
      din = '0; wr = '0; enq = '0; deq = '0;
      #2 rst = 1'b1;
      #1 check("async_reset", 16'(obs), 16'(RST_OBS));
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [15:0] w;
   logic [7:0]  a5;

   initial begin
      rst = 1'b1; din = '0; wr = '0; enq = '0; deq = '0;
      a5 = 8'hA5;
      @(negedge clk);
      @(negedge clk);
      check("reset_state", 16'(obs), 16'(RST_OBS));
      rst = 1'b0;
      @(negedge clk);
      check("after_reset_idle", 16'(obs), 16'(RST_OBS));

`ifndef PARITY_EN
      for (int i = 0; i < 8; i++)
         tbl[i] = mk(a5[7-i], '1, '0, '0, 1'(i != 7), '0, '0, 3'd0, '0, '1, '0);
      tbl[8] = mk('0, '0, '1, '0, '1, '0, '0, 3'd1, '0, '0, '0);
      tbl[9] = mk('0, '0, '0, '1, '1, '1, '1, 3'd0, '0, '1, '0);
      for (int i = 1; i < 8; i++)
         tbl[9+i] = mk('0, '0, '0, '0, '1, '1, a5[7-i], 3'd0, '0, '1, '0);
      tbl[17] = mk('0, '0, '0, '0, '1, '0, '0, 3'd0, '0, '1, '0);
      for (int i = 0; i < 18; i++) begin
         step(tbl[i].din, tbl[i].wr, tbl[i].enq, tbl[i].deq);
         check($sformatf("a5_vec%0d", i), 16'(obs), 16'(tbl[i].exp));
      end

      // Fill to full, then overflow.
      for (int k = 1; k <= 4; k++) begin
         send_bits(16'(k), 8);
         step('0, '0, '1, '0);
         check("push_len", 16'(len_out), 16'(k));
      end
      check("full_flags", 16'({full_out, empty_out, status_out}), 16'b101);
      send_bits(16'h05, 8);
      check("hold_status", 16'(status_out), 16'd0);
      step('0, '0, '1, '0);
      check("overflow", 16'(obs), 16'(10'b0_0_0_100_1_0_1_0));
      step('0, '0, '0, '0);
      check("overflow_sticky", 16'(obs), 16'(10'b0_0_0_100_1_0_1_0));

      // Push and pop together while full: word 05 lands in wrapped slot 0.
      step('0, '0, '1, '1);
      check("push_pop_full", 16'(obs), 16'(10'b1_1_0_100_1_0_1_0));
      recv('0, 8, w);
      check("tx_word01", w, 16'h01);
      for (int k = 2; k <= 5; k++) begin
         recv('1, 8, w);
         check("tx_word_fifo", w, 16'(k));
      end
      check("drained", 16'(obs), 16'(10'b1_0_0_000_0_1_1_0));
      step('0, '0, '0, '1);
      check("deq_empty_ignored", 16'(obs), 16'(10'b1_0_0_000_0_1_1_0));

      // Reset in the middle of a word, then a clean word.
      send_bits(16'b110, 3);
      pulse_reset();
      send_bits(16'h5A, 8);
      step('0, '0, '1, '0);
      check("after_rst_len", 16'(len_out), 16'd1);
      recv('1, 8, w);
      check("tx_word5a", w, 16'h5A);

      // Reset in the middle of a transmit.
      send_bits(16'h96, 8);
      step('0, '0, '1, '0);
      step('0, '0, '0, '1);
      step('0, '0, '0, '0);
      step('0, '0, '0, '0);
      pulse_reset();
      send_bits(16'h3C, 8);
      step('0, '0, '1, '0);
      check("after_txrst", 16'(obs), 16'(10'b1_0_0_001_0_0_0_0));
      recv('1, 8, w);
      check("tx_word3c", w, 16'h3C);
`else
      send_bits(16'h007, 9);
      check("parity_bad", 16'(obs), 16'(10'b1_0_0_000_0_1_0_1));
      step('0, '0, '0, '0);
      check("parity_pulse_end", 16'(obs), 16'(RST_OBS));
      step('0, '0, '1, '0);
      check("parity_bad_no_push", 16'(len_out), 16'd0);
      send_bits(16'h006, 9);
      check("parity_good", 16'(obs), 16'(10'b0_0_0_000_0_1_0_0));
      step('0, '0, '1, '0);
      check("parity_push", 16'(len_out), 16'd1);
      recv('1, 9, w);
      check("tx_parity_frame", w, 16'h006);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
